// File: rtl/envelope_voice_mixer.sv
// Envelope-scaled voice mixer: snapshots all voices on sample_tick, accumulates
// sample*amplitude one voice per clock, then shifts and saturates one mixed sample.
module envelope_voice_mixer #(
    parameter int NUM_VOICES  = 4,
    parameter int SAMPLE_BITS = 12,
    parameter int OUT_BITS    = 12,
    parameter int MIX_SHIFT   = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sample_tick,
    input  logic [NUM_VOICES*SAMPLE_BITS-1:0] voice_sample,
    input  logic [NUM_VOICES*8-1:0]           voice_amplitude,
    input  logic [NUM_VOICES-1:0]             voice_enable,
    output logic [OUT_BITS-1:0]               mix_out,
    output logic                              mix_valid,
    output logic                              busy,
    output logic                              overrun
);

    localparam int PW = SAMPLE_BITS + 9;
    localparam int AW = PW + $clog2(NUM_VOICES);
    localparam int SW = (AW > OUT_BITS + 1) ? AW : OUT_BITS + 1;
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int SH = 8 + MIX_SHIFT;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);
    localparam logic signed [SW-1:0] MAX_V = {{(SW-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;
    logic   start;
    logic   ovr_set;

    logic [NUM_VOICES*SAMPLE_BITS-1:0] snap_sample;
    logic [NUM_VOICES*8-1:0]           snap_amp;
    logic [NUM_VOICES-1:0]             snap_en;
    logic [IW-1:0]                     idx;
    logic signed [PW-1:0]              prod;
    logic signed [AW-1:0]              acc;

    logic signed [SAMPLE_BITS-1:0]     cur_sample;
    logic [7:0]                        cur_amp;
    logic                              cur_en;
    logic signed [PW-1:0]              prod_next;
    logic signed [SW-1:0]              sum_full;
    logic signed [SW-1:0]              shifted;
    logic [OUT_BITS-1:0]               sat_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE is the cycle mix_valid is shown; a tick there starts the next mix at once.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        ovr_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (sample_tick) begin
                    start      = 1'b1;
                    next_state = S_MAC;
                end
            end
            S_MAC: begin
                ovr_set = sample_tick;
                if (idx == LAST_IDX) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                ovr_set    = sample_tick;
                next_state = S_DONE;
            end
            S_DONE: begin
                if (sample_tick) begin
                    start      = 1'b1;
                    next_state = S_MAC;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cur_sample = snap_sample[int'(idx)*SAMPLE_BITS +: SAMPLE_BITS];
        cur_amp    = snap_amp[int'(idx)*8 +: 8];
        cur_en     = snap_en[idx];
        prod_next  = '0;
        if (cur_en) begin
            prod_next = PW'(cur_sample) * PW'($signed({1'b0, cur_amp}));
        end
    end

    // The final product is folded in combinationally so the result registers at the end of DRAIN.
    always_comb begin
        sum_full = SW'(acc) + SW'(prod);
        shifted  = sum_full >>> SH;
        if (shifted > MAX_V) begin
            sat_val = MAX_V[OUT_BITS-1:0];
        end else if (shifted < MIN_V) begin
            sat_val = MIN_V[OUT_BITS-1:0];
        end else begin
            sat_val = shifted[OUT_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_sample <= '0;
            snap_amp    <= '0;
            snap_en     <= '0;
            idx         <= '0;
            prod        <= '0;
            acc         <= '0;
            mix_out     <= '0;
            mix_valid   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            busy      <= (next_state == S_MAC) || (next_state == S_DRAIN);
            if (ovr_set) begin
                overrun <= 1'b1;
            end
            if (start) begin
                snap_sample <= voice_sample;
                snap_amp    <= voice_amplitude;
                snap_en     <= voice_enable;
                idx         <= '0;
                prod        <= '0;
                acc         <= '0;
            end
            if (state == S_MAC) begin
                prod <= prod_next;
                acc  <= acc + AW'(prod);
                if (idx != LAST_IDX) begin
                    idx <= idx + 1'b1;
                end
            end
            if (state == S_DRAIN) begin
                acc       <= acc + AW'(prod);
                mix_out   <= sat_val;
                mix_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_envelope_voice_mixer.sv
// Bench for envelope_voice_mixer: directed vector table, random vectors against an
// arithmetic reference model, and cycle-exact overrun / reset-abort sequences.
module tb_envelope_voice_mixer;

    localparam int NV = 4;
    localparam int SB = 12;
    localparam int OB = 12;

    logic               clk;
    logic               rst;
    logic               sample_tick;
    logic [NV*SB-1:0]   voice_sample;
    logic [NV*8-1:0]    voice_amplitude;
    logic [NV-1:0]      voice_enable;
    logic signed [OB-1:0] mix_out;
    logic               mix_valid;
    logic               busy;
    logic               overrun;

    typedef struct {
        int         s[NV];
        int         a[NV];
        logic [3:0] en;
        int         exp;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic exp_ovr = 1'b0;
    logic [OB-1:0] exp_q[$];
    vec_t tab[9];

    envelope_voice_mixer #(
        .NUM_VOICES(NV), .SAMPLE_BITS(SB), .OUT_BITS(OB), .MIX_SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .voice_sample(voice_sample), .voice_amplitude(voice_amplitude),
        .voice_enable(voice_enable), .mix_out(mix_out), .mix_valid(mix_valid),
        .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                                input int a0, input int a1, input int a2, input int a3,
                                input logic [3:0] en, input int exp);
        vec_t v;
        v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.en = en;
        v.exp = exp;
        return v;
    endfunction

    // Reference: plain integer sum of enabled sample*amp, floor-divide by 256, clamp.
    function automatic int model(input vec_t v);
        longint sum = 0;
        for (int k = 0; k < NV; k++) begin
            if (v.en[k]) sum += longint'(v.s[k]) * longint'(v.a[k]);
        end
        sum = sum >>> 8;
        if (sum > 2047) sum = 2047;
        if (sum < -2048) sum = -2048;
        return int'(sum);
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        logic loud;
        loud = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < NV; k++) begin
            v.s[k] = int'($urandom_range(0, 4095)) - 2048;
            v.a[k] = loud ? 255 : int'($urandom_range(0, 255));
        end
        v.en = 4'($urandom_range(0, 15));
        v.exp = 0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        int t;
        for (int k = 0; k < NV; k++) begin
            t = v.s[k];
            voice_sample[k*SB +: SB] = t[SB-1:0];
            t = v.a[k];
            voice_amplitude[k*8 +: 8] = t[7:0];
        end
        voice_enable = v.en;
    endtask

    // Called in the tick cycle; returns in the cycle mix_valid is expected.
    task automatic run_mix(input vec_t v, input int exp, input string tag);
        logic [OB-1:0] want;
        drive(v);
        sample_tick = 1'b1;
        exp_q.push_back(OB'(exp));
        step();
        sample_tick = 1'b0;
        drive(rand_vec());
        for (int c = 1; c <= 5; c++) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_early_valid"}, mix_valid, 0);
            step();
        end
        chk({tag, "_valid"}, mix_valid, 1);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_overrun"}, overrun, exp_ovr);
        want = exp_q.pop_front();
        chk({tag, "_mix_out"}, mix_out, $signed(want));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_tick = 1'b1;
        step();
        step();
        rst = 1'b0;
        sample_tick = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sample_tick = 1'b0;
        voice_sample = '0;
        voice_amplitude = '0;
        voice_enable = '0;

        tab[0] = mk(1000, 0, 0, 0, 255, 0, 0, 0, 4'b0001, 996);
        tab[1] = mk(-1000, 0, 0, 0, 255, 0, 0, 0, 4'b0001, -997);
        tab[2] = mk(2047, 2047, 2047, 2047, 255, 255, 255, 255, 4'b1111, 2047);
        tab[3] = mk(-2048, -2048, -2048, -2048, 255, 255, 255, 255, 4'b1111, -2048);
        tab[4] = mk(2047, 2047, 2047, 2047, 255, 255, 255, 255, 4'b0001, 2039);
        tab[5] = mk(100, -300, 0, 0, 128, 64, 0, 0, 4'b0011, -25);
        tab[6] = mk(2047, 2047, 2047, 2047, 0, 0, 0, 0, 4'b1111, 0);
        tab[7] = mk(500, 500, 500, 500, 255, 255, 255, 255, 4'b0000, 0);
        tab[8] = mk(-1, 0, 0, 0, 1, 0, 0, 0, 4'b0001, -1);

        // Reset state; the tick held during reset must be ignored.
        do_reset();
        chk("rst_mix_out", mix_out, 0);
        chk("rst_valid", mix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        step();
        chk("rst_tick_ignored", busy, 0);
        step();

        // Directed table, back-to-back: each mix is ticked in the previous one's valid cycle.
        for (int i = 0; i < 9; i++) begin
            run_mix(tab[i], tab[i].exp, $sformatf("vec%0d", i));
        end
        step();
        chk("single_pulse", mix_valid, 0);

        // Random vectors against the reference model.
        for (int i = 0; i < 25; i++) begin
            vec_t v;
            v = rand_vec();
            run_mix(v, model(v), $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) step();
        end
        step();

        // Overrun: tick at cycle 0 and cycle 3, then a tick at cycle 6 is accepted.
        do_reset();
        drive(tab[0]);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk("ovr_c1", overrun, 0);
        step();
        step();
        chk("ovr_c3", overrun, 0);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        chk("ovr_c4", overrun, 1);
        chk("ovr_c4_valid", mix_valid, 0);
        step();
        chk("ovr_c5_valid", mix_valid, 0);
        step();
        chk("ovr_c6_valid", mix_valid, 1);
        chk("ovr_c6_mix_out", mix_out, 996);
        chk("ovr_c6_sticky", overrun, 1);
        exp_ovr = 1'b1;
        run_mix(tab[1], -997, "ovr_next");
        step();
        chk("ovr_after_valid", mix_valid, 0);
        chk("ovr_held", overrun, 1);

        // Reset mid-mix: abort at cycle 3, fresh tick at cycle 4 completes at cycle 10.
        do_reset();
        run_mix(tab[0], 996, "pre_abort");
        step();
        drive(tab[2]);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        chk("abort_c2_valid", mix_valid, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_mix_out", mix_out, 0);
        chk("abort_valid", mix_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_overrun", overrun, 0);
        exp_ovr = 1'b0;
        run_mix(tab[5], -25, "post_abort");
        step();
        chk("post_abort_pulse", mix_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
